alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
// - Parametrised, registered successor of the 8-bit combinational datapath ALU used by the factorial datapath.
// - Same 3-bit opcode map. Multiplication becomes a multi-cycle shift-add unit, so no wide combinational multiplier is built.
// - Adds a start/busy/done handshake so the controller FSM waits on done instead of a fixed cycle count.
// - Result is held in an output register between operations.
// PARAMETERS
// - WIDTH  default 8   operand/result width in bits; legal range 4..32
// - CNT_W  default 5   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clk          input   1      rising-edge clock
// - rst_n        input   1      asynchronous reset, active low
// - start_alu_i  input   1      launch request; sampled only in IDLE
// - a_alu_i      input   WIDTH  operand A; captured when start is accepted
// - b_alu_i      input   WIDTH  operand B; captured when start is accepted
// - Sel_alu      input   3      opcode; captured when start is accepted
// - busy_alu_o   output  1      high while an operation is in flight
// - done_alu_o   output  1      one-cycle pulse when alu_o is updated
// - alu_o        output  WIDTH  result register
// - zero_alu_o   output  1      result==0            (ALU_FLAGS_EN only)
// - carry_alu_o  output  1      carry/borrow/mul-ovf  (ALU_FLAGS_EN only)
// BEHAVIOUR
// - Opcodes (all results mod 2**WIDTH):
//   - 000 MUL A*B (low WIDTH bits)
//   - 001 A&B
//   - 010 A^B
//   - 011 A|B
//   - 100 A-1
//   - 101 A+B
//   - 110 A-B
//   - 111 A+1
// - Reset: async, all state cleared. State=IDLE; alu_o=0, busy=0, done=0, flags=0.
// - FSM states:
//   - IDLE: start_alu_i=1 captures A, B and Sel; goes to MUL if Sel==000, else to EXEC.
//   - EXEC: computes the single-cycle op from the captured operands, loads alu_o, pulses done, returns to IDLE.
//   - MUL: each cycle, if B[0] then acc+=A; A<<=1; B>>=1; cnt++. When cnt==WIDTH-1 on that add, loads alu_o=acc, pulses done, returns to IDLE.
// - Latency from the start-accept edge to the done pulse:
//   - logic/add/sub/inc/dec: 1 cycle
//   - MUL: WIDTH cycles (always the full count; no early exit on B==0)
// - busy_alu_o is high in EXEC and MUL and low in IDLE. It deasserts in the same cycle done is high.
// - Start while busy is ignored; no queueing. Start in the same cycle as done is ignored; it must be re-asserted in IDLE.
// - Inputs may change freely after acceptance; only the captured copies are used.
// - alu_o and the flags hold their last value until the next done pulse.
// - MUL accumulator is WIDTH+WIDTH bits internally; only the low WIDTH bits reach alu_o.
// - Reset asserted mid-operation aborts it: no done pulse, alu_o=0.
// CONFIGURATION
// - Macro ALU_FLAGS_EN.
// - Defined:
//   - zero_alu_o and carry_alu_o ports exist and are registered together with alu_o.
//   - carry = bit WIDTH of the sum (ADD, INC).
//   - carry = borrow (SUB, DEC; e.g. 0-1 gives carry=1).
//   - carry = OR of the high WIDTH bits of the product (MUL).
//   - carry = 0 for AND, XOR and OR.
// - Undefined: both ports and their logic are absent; all other behaviour is identical.
// TESTING (WIDTH=8, ALU_FLAGS_EN defined unless noted)
// - Reset: hold rst_n=0 -> alu_o=0, busy=0, done=0, zero=0, carry=0.
// - MUL 5*6: start -> busy for 8 cycles, done on the 8th cycle after accept, alu_o=30, carry=0.
// - MUL 20*20 -> alu_o=144 (400 mod 256), carry=1; operands changed after accept have no effect.
// - Single-cycle ops:
//   - ADD 200+100 -> alu_o=44, carry=1, done 1 cycle after accept.
//   - DEC 0 -> 255, carry=1.
//   - XOR 0x5A^0x5A -> 0, zero=1.
// - Start while busy: second start during a MUL is ignored; exactly one done, first result kept.
// - Reset mid-MUL: rst_n=0 at cycle 3 -> no done, alu_o=0. Next MUL 3*7 -> 21.
// - ALU_FLAGS_EN undefined: rerun the 5*6 and 200+100 cases -> same alu_o and timing.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done handshake and operand/result bus of alu_seq.
//   master : controller side (drives start, operands, opcode; sees status/result)
//   slave  : ALU side
// Signals:
//   start_alu_i  launch request
//   a_alu_i      operand A
//   b_alu_i      operand B
//   Sel_alu      3-bit opcode
//   busy_alu_o   operation in flight
//   done_alu_o   one-cycle result-update pulse
//   alu_o        result register
//   zero_alu_o   result == 0            (only with ALU_FLAGS_EN)
//   carry_alu_o  carry/borrow/mul-ovf   (only with ALU_FLAGS_EN)
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start_alu_i;
  logic [WIDTH-1:0] a_alu_i;
  logic [WIDTH-1:0] b_alu_i;
  logic [2:0]       Sel_alu;
  logic             busy_alu_o;
  logic             done_alu_o;
  logic [WIDTH-1:0] alu_o;
`ifdef ALU_FLAGS_EN
  logic             zero_alu_o;
  logic             carry_alu_o;
`endif

  modport master (
    output start_alu_i, a_alu_i, b_alu_i, Sel_alu,
    input  busy_alu_o, done_alu_o, alu_o
`ifdef ALU_FLAGS_EN
    , input zero_alu_o, carry_alu_o
`endif
  );

  modport slave (
    input  start_alu_i, a_alu_i, b_alu_i, Sel_alu,
    output busy_alu_o, done_alu_o, alu_o
`ifdef ALU_FLAGS_EN
    , output zero_alu_o, carry_alu_o
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake. Multiplication is a
// multi-cycle shift-add unit (WIDTH cycles); all other ops take one cycle.
// Opcodes: 000 MUL, 001 AND, 010 XOR, 011 OR, 100 A-1, 101 A+B, 110 A-B, 111 A+1.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   bus    alu_seq_if.slave (start, operands, opcode, busy, done, result, flags)
// Optional feature: define ALU_FLAGS_EN to add registered zero/carry flags.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;

  logic [1:0]         state;
  logic [2:0]         sel_r;
  logic [2*WIDTH-1:0] a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   alu_r;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   exec_res;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_mul;

  // A is held zero-extended so the multiplier can shift it left in place.
  assign op_a     = a_r[WIDTH-1:0];
  assign acc_next = acc + (b_r[0] ? a_r : '0);
  assign last_mul = (cnt == CNT_W'(WIDTH-1));

  always_comb begin
    exec_res = '0;
    case (sel_r)
      3'b001:  exec_res = op_a & b_r;
      3'b010:  exec_res = op_a ^ b_r;
      3'b011:  exec_res = op_a | b_r;
      3'b100:  exec_res = op_a - WIDTH'(1);
      3'b101:  exec_res = op_a + b_r;
      3'b110:  exec_res = op_a - b_r;
      3'b111:  exec_res = op_a + WIDTH'(1);
      default: exec_res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic             zero_r;
  logic             carry_r;
  logic             exec_carry;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;

  // Borrow of a subtraction shows up as bit WIDTH of the extended difference.
  assign add_ext = {1'b0, op_a} + {1'b0, (sel_r == 3'b111) ? WIDTH'(1) : b_r};
  assign sub_ext = {1'b0, op_a} - {1'b0, (sel_r == 3'b100) ? WIDTH'(1) : b_r};

  always_comb begin
    exec_carry = 1'b0;
    case (sel_r)
      3'b101, 3'b111: exec_carry = add_ext[WIDTH];
      3'b100, 3'b110: exec_carry = sub_ext[WIDTH];
      default:        exec_carry = 1'b0;
    endcase
  end

  assign bus.zero_alu_o  = zero_r;
  assign bus.carry_alu_o = carry_r;
`endif

  assign bus.busy_alu_o = busy_r;
  assign bus.done_alu_o = done_r;
  assign bus.alu_o      = alu_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      alu_r   <= '0;
`ifdef ALU_FLAGS_EN
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped on purpose.
          if (bus.start_alu_i && !done_r) begin
            a_r    <= {{WIDTH{1'b0}}, bus.a_alu_i};
            b_r    <= bus.b_alu_i;
            sel_r  <= bus.Sel_alu;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= (bus.Sel_alu == 3'b000) ? MUL : EXEC;
          end
        end
        EXEC: begin
          alu_r   <= exec_res;
`ifdef ALU_FLAGS_EN
          zero_r  <= (exec_res == '0);
          carry_r <= exec_carry;
`endif
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        MUL: begin
          acc <= acc_next;
          a_r <= a_r << 1;
          b_r <= b_r >> 1;
          cnt <= cnt + CNT_W'(1);
          if (last_mul) begin
            alu_r   <= acc_next[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
            zero_r  <= (acc_next[WIDTH-1:0] == '0);
            carry_r <= |acc_next[2*WIDTH-1:WIDTH];
`endif
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [W-1:0] ref_res(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] s);
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned r;
    case (s)
      3'd0: r = ai * bi;
      3'd1: r = ai & bi;
      3'd2: r = ai ^ bi;
      3'd3: r = ai | bi;
      3'd4: r = ai - 1;
      3'd5: r = ai + bi;
      3'd6: r = ai - bi;
      default: r = ai + 1;
    endcase
    return W'(r % (1 << W));
  endfunction

  function automatic bit ref_carry(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] s);
    int unsigned ai = a;
    int unsigned bi = b;
    case (s)
      3'd0: return (ai * bi) >= (1 << W);
      3'd4: return ai == 0;
      3'd5: return (ai + bi) >= (1 << W);
      3'd6: return ai < bi;
      3'd7: return ai == (1 << W) - 1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: a countdown of remaining cycles plus the precomputed result.
  int           m_left = 0;
  logic [W-1:0] m_alu  = '0;
  logic         m_done = 1'b0;
  logic [W-1:0] p_res  = '0;
`ifdef ALU_FLAGS_EN
  logic         m_zero  = 1'b0;
  logic         m_carry = 1'b0;
  logic         p_c     = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_alu   <= '0;
      m_done  <= 1'b0;
`ifdef ALU_FLAGS_EN
      m_zero  <= 1'b0;
      m_carry <= 1'b0;
`endif
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_alu   <= p_res;
          m_done  <= 1'b1;
`ifdef ALU_FLAGS_EN
          m_zero  <= (p_res == '0);
          m_carry <= p_c;
`endif
        end
      end else if (bus.start_alu_i && !m_done) begin
        p_res  <= ref_res(bus.a_alu_i, bus.b_alu_i, bus.Sel_alu);
`ifdef ALU_FLAGS_EN
        p_c    <= ref_carry(bus.a_alu_i, bus.b_alu_i, bus.Sel_alu);
`endif
        m_left <= (bus.Sel_alu == 3'd0) ? W : 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("alu_o", 64'(bus.alu_o), 64'(m_alu));
    chk("busy", 64'(bus.busy_alu_o), 64'(m_left != 0));
    chk("done", 64'(bus.done_alu_o), 64'(m_done));
`ifdef ALU_FLAGS_EN
    chk("zero", 64'(bus.zero_alu_o), 64'(m_zero));
    chk("carry", 64'(bus.carry_alu_o), 64'(m_carry));
`endif
  end

  // Launch one op, scramble inputs after acceptance, return edges to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                        output int lat, output logic busy1);
    @(negedge clk);
    bus.start_alu_i = 1'b1;
    bus.a_alu_i     = a;
    bus.b_alu_i     = b;
    bus.Sel_alu     = s;
    @(negedge clk);
    bus.start_alu_i = 1'b0;
    bus.a_alu_i     = W'($urandom);
    bus.b_alu_i     = W'($urandom);
    bus.Sel_alu     = 3'($urandom);
    busy1 = bus.busy_alu_o;
    lat = 0;
    while (!bus.done_alu_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int   lat;
  logic busy1;
  int   dones;

  initial begin
    rst_n           = 1'b0;
    bus.start_alu_i = 1'b0;
    bus.a_alu_i     = '0;
    bus.b_alu_i     = '0;
    bus.Sel_alu     = '0;
    repeat (3) @(negedge clk);
    chk("rst_alu", 64'(bus.alu_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_alu_o), 64'd0);
    chk("rst_done", 64'(bus.done_alu_o), 64'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_zero", 64'(bus.zero_alu_o), 64'd0);
    chk("rst_carry", 64'(bus.carry_alu_o), 64'd0);
`endif
    @(posedge clk); #2 rst_n = 1'b1;

    run_op(8'd5, 8'd6, 3'd0, lat, busy1);
    chk("mul5x6_busy", 64'(busy1), 64'd1);
    chk("mul5x6_lat", 64'(lat), 64'd8);
    chk("mul5x6_res", 64'(bus.alu_o), 64'd30);
    chk("mul5x6_busy_at_done", 64'(bus.busy_alu_o), 64'd0);
`ifdef ALU_FLAGS_EN
    chk("mul5x6_carry", 64'(bus.carry_alu_o), 64'd0);
`endif

    run_op(8'd20, 8'd20, 3'd0, lat, busy1);
    chk("mul20x20_res", 64'(bus.alu_o), 64'd144);
`ifdef ALU_FLAGS_EN
    chk("mul20x20_carry", 64'(bus.carry_alu_o), 64'd1);
`endif

    run_op(8'd200, 8'd100, 3'd5, lat, busy1);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_res", 64'(bus.alu_o), 64'd44);
`ifdef ALU_FLAGS_EN
    chk("add_carry", 64'(bus.carry_alu_o), 64'd1);
`endif

    run_op(8'd0, 8'd0, 3'd4, lat, busy1);
    chk("dec0_res", 64'(bus.alu_o), 64'd255);
`ifdef ALU_FLAGS_EN
    chk("dec0_carry", 64'(bus.carry_alu_o), 64'd1);
`endif

    run_op(8'h5A, 8'h5A, 3'd2, lat, busy1);
    chk("xor_res", 64'(bus.alu_o), 64'd0);
`ifdef ALU_FLAGS_EN
    chk("xor_zero", 64'(bus.zero_alu_o), 64'd1);
`endif

    // Second start during a MUL must be ignored.
    @(negedge clk);
    bus.start_alu_i = 1'b1; bus.a_alu_i = 8'd5; bus.b_alu_i = 8'd6; bus.Sel_alu = 3'd0;
    @(negedge clk);
    bus.start_alu_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        bus.start_alu_i = 1'b1; bus.a_alu_i = 8'd1; bus.b_alu_i = 8'd1; bus.Sel_alu = 3'd5;
      end else begin
        bus.start_alu_i = 1'b0;
      end
      if (bus.done_alu_o) dones++;
      @(negedge clk);
    end
    chk("busy_start_dones", 64'(dones), 64'd1);
    chk("busy_start_res", 64'(bus.alu_o), 64'd30);

    // Reset three cycles into a MUL aborts it.
    @(negedge clk);
    bus.start_alu_i = 1'b1; bus.a_alu_i = 8'd9; bus.b_alu_i = 8'd9; bus.Sel_alu = 3'd0;
    @(negedge clk);
    bus.start_alu_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done_alu_o) dones++;
    end
    chk("rst_mid_dones", 64'(dones), 64'd0);
    chk("rst_mid_res", 64'(bus.alu_o), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op(8'd3, 8'd7, 3'd0, lat, busy1);
    chk("mul3x7_res", 64'(bus.alu_o), 64'd21);
    chk("mul3x7_lat", 64'(lat), 64'd8);

    // Random traffic, checked every cycle by the model compare.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start_alu_i = ($urandom_range(0, 2) == 0);
      bus.a_alu_i     = W'($urandom);
      bus.b_alu_i     = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      bus.Sel_alu     = 3'($urandom);
    end
    @(negedge clk);
    bus.start_alu_i = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
